hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC-V core, placed between decode and the pipeline-register write enables. It handles several hazard sources and arbitrates between them by priority:
- load-use with configurable load latency, honouring per-source register-use flags
- multi-cycle EX ops (mul/div) with configurable latency
- taken-branch/jump redirect flush
- data-memory wait freeze

It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, total stall cycles per load-use hazard (>=1)
MC_LAT, 4, cycles a multi-cycle op occupies EX (>=1; 1 = no stall)
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
id_ex_mem_rd  in  1  instruction in ID/EX is a load
id_ex_reg_wr  in  1  instruction in ID/EX writes rd
id_ex_rd  in  REG_AW  rd of instruction in ID/EX
if_id_rs1  in  REG_AW  rs1 of instruction in IF/ID
if_id_rs2  in  REG_AW  rs2 of instruction in IF/ID
if_id_rs1_used  in  1  IF/ID instruction reads rs1
if_id_rs2_used  in  1  IF/ID instruction reads rs2
ex_mc_op  in  1  ID/EX holds a multi-cycle op (level)
ex_redirect  in  1  EX resolves a taken branch or jump
dmem_ready  in  1  data memory access completes this cycle
pc_wr  out  1  PC write enable
if_id_wr  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_wr  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX loads a bubble
ex_mem_wr  out  1  EX/MEM write enable
ex_mem_flush  out  1  EX/MEM loads a bubble
mem_wb_wr  out  1  MEM/WB write enable
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- States: IDLE, LU_WAIT, MC_WAIT. A down-counter of width clog2(max(LOAD_LAT,MC_LAT))+1 and a mc_done flag are held in registers.
- Reset (rstn low, asynchronous):
  - state IDLE, counter 0, mc_done 0, stall_cnt 0.
  - All *_wr and *_flush outputs 0 while rstn is low.
- Default (no hazard): all *_wr 1, all *_flush 0.
- Priority, highest first: memory freeze > MC stall > redirect > load-use.
- Memory freeze (dmem_ready=0):
  - all *_wr 0, all flushes 0.
  - state, counter and mc_done hold.
  - stall_cnt increments.
- lu_hit = id_ex_mem_rd & id_ex_reg_wr & (id_ex_rd!=0) & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)).
- Load-use:
  - IDLE & lu_hit: pc_wr=0, if_id_wr=0, id_ex_flush=1 in the same cycle.
  - If LOAD_LAT>1, load counter with LOAD_LAT-1 and go to LU_WAIT.
  - LU_WAIT: same outputs. Counter decrements each cycle; leave to IDLE after the cycle where counter==1.
  - Total stall is exactly LOAD_LAT cycles.
- Multi-cycle op (ex_mc_op rises in EX at cycle t):
  - Cycles t..t+MC_LAT-2: pc_wr=0, if_id_wr=0, id_ex_wr=0, ex_mem_flush=1 (op held in EX, bubbles go to MEM).
  - Cycle t+MC_LAT-1: normal advance; set mc_done.
  - mc_done blocks re-trigger by the same op. It clears on the first cycle ex_mc_op=0 or when id_ex_wr=1 with a new instruction.
  - Back-to-back mul ops therefore each stall MC_LAT-1 cycles.
  - Implemented via MC_WAIT with counter MC_LAT-2. MC_LAT=1 never stalls.
- Redirect (IDLE, ex_redirect=1):
  - if_id_flush=1, id_ex_flush=1, pc_wr=1 (target loads).
  - Overrides lu_hit in the same cycle: no load-use stall and no LU_WAIT entry, because the dependent instruction is squashed.
- Redirect while in MC_WAIT or LU_WAIT: cannot legally occur and is ignored. MC op in LU_WAIT: ignored until IDLE.
- stall_cnt:
  - +1 each cycle pc_wr=0 while rstn high.
  - Saturates at 2^CNT_W-1, with no wrap.
- Reset mid-stall: immediate return to IDLE with counters cleared. The first cycle after release has default outputs unless a hazard is present.

Test Plan:
- Load x5 in EX, IF/ID add reads rs2=x5, rs2_used=1, LOAD_LAT=1 -> exactly 1 cycle pc_wr=0, if_id_wr=0, id_ex_flush=1; stall_cnt=1.
- Same with LOAD_LAT=3 -> 3 consecutive stall cycles; dmem_ready=0 for 2 cycles in the middle -> 5 total stall cycles, stall_cnt=5.
- Load to x0, or rs match with rs_used=0 (e.g. lui) -> no stall.
- MC_LAT=4, two consecutive mul ops -> id_ex_wr low 3 cycles, high 1, low 3, high 1; ex_mem_flush high during each low period.
- lu_hit and ex_redirect same cycle -> if_id_flush=1, id_ex_flush=1, pc_wr=1; next cycle default outputs.
- rstn pulled low during LU_WAIT (LOAD_LAT=3) -> outputs 0 immediately; after release state IDLE, stall_cnt=0. CNT_W=4 with 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory freeze, multi-cycle EX stalls,
// branch redirect flushes and load-use stalls into pipeline-register controls.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_ex_mem_rd,
    input  logic              id_ex_reg_wr,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_rs1_used,
    input  logic              if_id_rs2_used,
    input  logic              ex_mc_op,
    input  logic              ex_redirect,
    input  logic              dmem_ready,
    output logic              pc_wr,
    output logic              if_id_wr,
    output logic              if_id_flush,
    output logic              id_ex_wr,
    output logic              id_ex_flush,
    output logic              ex_mem_wr,
    output logic              ex_mem_flush,
    output logic              mem_wb_wr,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, LU_WAIT, MC_WAIT} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             mc_done_reg, mc_done_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             lu_hit;
    logic             mc_start;

    assign lu_hit = id_ex_mem_rd && id_ex_reg_wr && (id_ex_rd != '0) &&
                    ((if_id_rs1_used && (id_ex_rd == if_id_rs1)) ||
                     (if_id_rs2_used && (id_ex_rd == if_id_rs2)));

    // mc_done keeps the op that just finished from stalling a second time
    assign mc_start = (MC_LAT > 1) && ex_mc_op && !mc_done_reg;

    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mc_done_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mc_done_reg <= mc_done_next;
            if (!pc_wr && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mc_done_next = mc_done_reg;
        if (dmem_ready) begin
            if (mc_done_reg && (!ex_mc_op || id_ex_wr))
                mc_done_next = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mc_start) begin
                        if (MC_LAT > 2) begin
                            state_next = MC_WAIT;
                            cnt_next   = CW'(MC_LAT - 2);
                        end else begin
                            mc_done_next = 1'b1;
                        end
                    end else if (!ex_redirect && lu_hit && (LOAD_LAT > 1)) begin
                        state_next = LU_WAIT;
                        cnt_next   = CW'(LOAD_LAT - 1);
                    end
                end
                LU_WAIT: begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1))
                        state_next = IDLE;
                end
                MC_WAIT: begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_next   = IDLE;
                        mc_done_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_wr     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_wr    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_wr    = 1'b1;
        if (!rstn || !dmem_ready) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_mem_wr = 1'b0;
            mem_wb_wr = 1'b0;
        end else if ((state_reg == MC_WAIT) || ((state_reg == IDLE) && mc_start)) begin
            // op stays in EX, bubbles drain into MEM
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_ex_wr     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (state_reg == LU_WAIT) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_hit) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances with different latencies share stimulus
// and are compared every cycle against a remaining-stall-cycles reference model.
module tb_hazard_ctrl;
    localparam logic [7:0] DEF = 8'hD5;  // {pc,ifw,iff,idw,idf,exw,exf,mw}
    localparam logic [7:0] MCS = 8'h07;
    localparam logic [7:0] LUS = 8'h1D;
    localparam logic [7:0] RED = 8'hFD;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       mem_rd = 1'b0, reg_wr = 1'b0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic       u1 = 1'b0, u2 = 1'b0;
    logic       mc_op = 1'b0, redirect = 1'b0, dmem_ready = 1'b1;

    logic        pc_a, ifw_a, iff_a, idw_a, idf_a, exw_a, exf_a, mw_a;
    logic        pc_b, ifw_b, iff_b, idw_b, idf_b, exw_b, exf_b, mw_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    logic [7:0]  o_a, o_b;

    int checks = 0;
    int errors = 0;

    int  ll[2]   = '{3, 1};
    int  ml[2]   = '{4, 2};
    int  cmax[2] = '{15, 65535};
    int  lu_rem[2], mc_rem[2], scnt[2];
    bit  served[2];
    int  n_lu[2], n_mc[2], n_cnt[2];
    bit  n_srv[2];
    logic [7:0] exp_o[2];
    int  exp_cnt[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MC_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rstn(rstn), .id_ex_mem_rd(mem_rd), .id_ex_reg_wr(reg_wr),
        .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .ex_mc_op(mc_op),
        .ex_redirect(redirect), .dmem_ready(dmem_ready),
        .pc_wr(pc_a), .if_id_wr(ifw_a), .if_id_flush(iff_a), .id_ex_wr(idw_a),
        .id_ex_flush(idf_a), .ex_mem_wr(exw_a), .ex_mem_flush(exf_a),
        .mem_wb_wr(mw_a), .stall_cnt(cnt_a));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MC_LAT(2), .CNT_W(16)) dut_b (
        .clk(clk), .rstn(rstn), .id_ex_mem_rd(mem_rd), .id_ex_reg_wr(reg_wr),
        .id_ex_rd(rd), .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_rs1_used(u1), .if_id_rs2_used(u2), .ex_mc_op(mc_op),
        .ex_redirect(redirect), .dmem_ready(dmem_ready),
        .pc_wr(pc_b), .if_id_wr(ifw_b), .if_id_flush(iff_b), .id_ex_wr(idw_b),
        .id_ex_flush(idf_b), .ex_mem_wr(exw_b), .ex_mem_flush(exf_b),
        .mem_wb_wr(mw_b), .stall_cnt(cnt_b));

    assign o_a = {pc_a, ifw_a, iff_a, idw_a, idf_a, exw_a, exf_a, mw_a};
    assign o_b = {pc_b, ifw_b, iff_b, idw_b, idf_b, exw_b, exf_b, mw_b};

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lu_hit_m();
        return mem_rd && reg_wr && (rd != 0) &&
               ((u1 && rd == rs1) || (u2 && rd == rs2));
    endfunction

    // Model: each hazard is a number of stall cycles still owed
    task automatic model_eval(int i);
        int lu, mc;
        bit srv, busy;
        logic [7:0] o;
        lu = lu_rem[i]; mc = mc_rem[i]; srv = served[i]; o = DEF;
        exp_cnt[i] = rstn ? scnt[i] : 0;
        if (!rstn) begin
            o = 8'h00; lu = 0; mc = 0; srv = 0;
        end else if (!dmem_ready) begin
            o = 8'h00;
        end else begin
            busy = (lu > 0) || (mc > 0);
            if (!busy && mc_op && !srv && ml[i] > 1) mc = ml[i] - 1;
            else if (!busy && redirect) o = RED;
            else if (!busy && lu_hit_m()) lu = ll[i];
            if (mc > 0) begin
                o = MCS; mc--;
                if (mc == 0) srv = 1;
            end else if (lu > 0) begin
                o = LUS; lu--;
            end
            if (served[i] && (!mc_op || o[4])) srv = 0;
        end
        exp_o[i] = o;
        n_lu[i] = lu; n_mc[i] = mc; n_srv[i] = srv;
        if (!rstn) n_cnt[i] = 0;
        else if (!o[7] && scnt[i] < cmax[i]) n_cnt[i] = scnt[i] + 1;
        else n_cnt[i] = scnt[i];
    endtask

    task automatic step();
        #1;
        model_eval(0);
        model_eval(1);
        check("outs_a", {24'd0, o_a}, {24'd0, exp_o[0]});
        check("outs_b", {24'd0, o_b}, {24'd0, exp_o[1]});
        check("cnt_a", {28'd0, cnt_a}, exp_cnt[0]);
        check("cnt_b", {16'd0, cnt_b}, exp_cnt[1]);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            lu_rem[i] = n_lu[i]; mc_rem[i] = n_mc[i];
            served[i] = n_srv[i]; scnt[i] = n_cnt[i];
        end
        @(negedge clk);
    endtask

    task automatic clear_in();
        mem_rd = 0; reg_wr = 0; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
        mc_op = 0; redirect = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        clear_in();
        rstn = 0; step(); rstn = 1;
    endtask

    initial begin
        logic [7:0] pat;
        for (int i = 0; i < 2; i++) begin
            lu_rem[i] = 0; mc_rem[i] = 0; scnt[i] = 0; served[i] = 0;
        end
        @(negedge clk);
        do_reset();
        check("reset_cnt_a", {28'd0, cnt_a}, 32'd0);

        // load x5 in EX, add reads rs2=x5; bubble follows
        mem_rd = 1; reg_wr = 1; rd = 5; rs1 = 1; rs2 = 5; u1 = 1; u2 = 1;
        step();
        mem_rd = 0; reg_wr = 0;
        for (int k = 0; k < 4; k++) step();
        check("lu1_cnt_b", {16'd0, cnt_b}, 32'd1);
        check("lu3_cnt_a", {28'd0, cnt_a}, 32'd3);

        // load-use with a 2-cycle memory freeze in the middle
        do_reset();
        mem_rd = 1; reg_wr = 1; rd = 5; rs2 = 5; u2 = 1;
        step();
        mem_rd = 0; reg_wr = 0; dmem_ready = 0;
        step(); step();
        dmem_ready = 1;
        for (int k = 0; k < 4; k++) step();
        check("lu_freeze_cnt_a", {28'd0, cnt_a}, 32'd5);
        check("lu_freeze_cnt_b", {16'd0, cnt_b}, 32'd3);

        // load to x0, and a matching rs that is not used
        clear_in();
        mem_rd = 1; reg_wr = 1; rd = 0; rs1 = 0; u1 = 1;
        #1 check("ld_x0_pc", {31'd0, pc_a}, 32'd1);
        step();
        rd = 7; rs1 = 7; u1 = 0; rs2 = 7; u2 = 0;
        #1 check("unused_rs_pc", {31'd0, pc_a}, 32'd1);
        step();

        // two back-to-back multi-cycle ops
        do_reset();
        pat = 8'b1000_1000;
        mc_op = 1;
        for (int k = 0; k < 8; k++) begin
            #1 check("mc_idw_a", {31'd0, idw_a}, {31'd0, pat[k]});
            check("mc_exf_a", {31'd0, exf_a}, {31'd0, ~pat[k]});
            step();
        end
        clear_in();
        step();

        // load-use and redirect together: redirect wins
        mem_rd = 1; reg_wr = 1; rd = 9; rs1 = 9; u1 = 1; redirect = 1;
        #1 check("redir_outs_a", {24'd0, o_a}, {24'd0, RED});
        step();
        clear_in();
        #1 check("after_redir_a", {24'd0, o_a}, {24'd0, DEF});
        step();

        // reset pulled while in LU_WAIT
        mem_rd = 1; reg_wr = 1; rd = 4; rs1 = 4; u1 = 1;
        step();
        clear_in();
        step();
        rstn = 0;
        #1 check("rst_mid_outs_a", {24'd0, o_a}, 32'd0);
        step();
        rstn = 1;
        #1 check("post_rst_outs_a", {24'd0, o_a}, {24'd0, DEF});
        check("post_rst_cnt_a", {28'd0, cnt_a}, 32'd0);
        step();

        // 20 frozen cycles saturate the 4-bit counter
        do_reset();
        dmem_ready = 0;
        for (int k = 0; k < 20; k++) step();
        dmem_ready = 1;
        step();
        check("sat_cnt_a", {28'd0, cnt_a}, 32'd15);
        check("sat_cnt_b", {16'd0, cnt_b}, 32'd20);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 800; k++) begin
            mem_rd     = ($urandom_range(0, 2) == 0);
            reg_wr     = ($urandom_range(0, 3) != 0);
            rd         = 5'($urandom_range(0, 3));
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            u1         = $urandom_range(0, 1) == 1;
            u2         = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) mc_op = ~mc_op;
            redirect   = ($urandom_range(0, 6) == 0);
            dmem_ready = ($urandom_range(0, 5) != 0);
            rstn       = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
